// File: rtl/integ_upsamp_m256_iw5_0.sv
// Single-stage CIC integrator with zero-stuffing upsampler (R = 1..256), AXI-Stream in/out.
// Define INTEG_FLUSH_EN to add a synchronous active-high 'flush' input that clears the integrator.
module integ_upsamp_m256_iw5_0 #(
  parameter int unsigned DATA_WIDTH = 48,
  parameter int unsigned RATE_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
`ifdef INTEG_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [RATE_WIDTH-1:0] rsetting,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                  m_axis_tready
);

  localparam int unsigned MAX_RATE = 256;

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
  logic [RATE_WIDTH-1:0] reff_m1;
  logic                  out_vld_q, out_vld_d;
  logic                  load;
  logic                  flush_i;

`ifdef INTEG_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Effective rate minus one: 0 behaves as 1, anything above 256 clamps to 256
  always_comb begin
    reff_m1 = '0;
    if (rsetting == '0) begin
      reff_m1 = '0;
    end else if (rsetting > RATE_WIDTH'(MAX_RATE)) begin
      reff_m1 = RATE_WIDTH'(MAX_RATE - 1);
    end else begin
      reff_m1 = rsetting - RATE_WIDTH'(1);
    end
  end

  // Output register is free or being drained this cycle
  assign load          = !out_vld_q | m_axis_tready;
  assign s_axis_tready = load & (cnt_q == '0) & !flush_i;

  // Next state: flush, then owed zero-stuffed samples, then a new input
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_vld_d = out_vld_q;
    if (flush_i) begin
      acc_d     = '0;
      cnt_d     = '0;
      out_vld_d = 1'b0;
    end else if (load) begin
      if (cnt_q != '0) begin
        cnt_d     = cnt_q - RATE_WIDTH'(1);
        out_vld_d = 1'b1;
      end else if (s_axis_tvalid) begin
        acc_d     = acc_q + s_axis_tdata;
        cnt_d     = reff_m1;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign m_axis_tdata  = acc_q;
  assign m_axis_tvalid = out_vld_q;

endmodule

// File: tb/tb_integ_upsamp_m256_iw5_0.sv
// Bench for integ_upsamp_m256_iw5_0: queue-of-owed-samples reference model checked every cycle,
// plus directed sequences with hand-computed output lists.
module tb_integ_upsamp_m256_iw5_0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [8:0]  rsetting = 9'd1;
  logic        s_axis_tvalid = 1'b0;
  logic [47:0] s_axis_tdata = '0;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [47:0] m_axis_tdata;
  logic        m_axis_tready = 1'b1;

  integer errors = 0;
  integer checks = 0;

  // Model: every output sample still owed (including the one on the bus) plus the running sum
  logic [47:0] mq[$];
  logic [47:0] macc = '0;
  logic [47:0] nacc;
  logic        exp_rdy;
  logic [47:0] out_log[$];
  logic [47:0] exp_q[$];

  integ_upsamp_m256_iw5_0 dut (
    .clk           (clk),
    .reset_n       (reset_n),
`ifdef INTEG_FLUSH_EN
    .flush         (flush),
`endif
    .rsetting      (rsetting),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clk = ~clk;

  function automatic int reff(input logic [8:0] r);
    if (r == 9'd0) return 1;
    if (int'(r) > 256) return 256;
    return int'(r);
  endfunction

  // A new input fits when nothing is owed, or only the last sample is left and it drains now
  assign exp_rdy = (mq.size() == 0) || (mq.size() == 1 && m_axis_tready);
  assign nacc    = macc + s_axis_tdata;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model update
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        macc = '0;
      end else begin
        if (mq.size() > 0 && m_axis_tready) void'(mq.pop_front());
        if (s_axis_tvalid && exp_rdy) begin
          macc = nacc;
          for (int i = 0; i < reff(rsetting); i++) mq.push_back(nacc);
        end
      end
    end
  end

  // Compare process, away from the active edge; also logs every output handshake
  initial begin
    forever begin
      @(negedge clk);
      chk("m_axis_tvalid", 64'(m_axis_tvalid), 64'(mq.size() != 0));
      chk("m_axis_tdata", 64'(m_axis_tdata), 64'(macc));
      chk("s_axis_tready", 64'(s_axis_tready), 64'(exp_rdy));
      if (reset_n && m_axis_tvalid && m_axis_tready) out_log.push_back(m_axis_tdata);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_log.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [47:0] x, input logic [8:0] r);
    bit done = 0;
    rsetting = r;
    s_axis_tdata = x;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    s_axis_tvalid = 1'b0;
    if (!done) begin
      errors = errors + 1;
      $display("FAIL send_timeout: input %0h never accepted", x);
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk); #1;
      if (mq.size() == 0) done = 1;
    end
    if (!done) begin
      errors = errors + 1;
      $display("FAIL drain_timeout: %0d samples still owed", mq.size());
    end
  endtask

  task automatic expect_rep(input logic [47:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_count"}, 64'(out_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < out_log.size() && i < exp_q.size(); i++)
      chk(nm, 64'(out_log[i]), 64'(exp_q[i]));
    out_log.delete();
    exp_q.delete();
  endtask

  initial begin
    do_reset();

    // R=4, inputs 5 then 3 back-to-back
    send(48'd5, 9'd4);
    send(48'd3, 9'd4);
    drain();
    expect_rep(48'd5, 4);
    expect_rep(48'd8, 4);
    check_log("r4_seq");

    // R=1 continuous running sum
    do_reset();
    for (int i = 1; i <= 4; i++) send(48'(i), 9'd1);
    drain();
    expect_rep(48'd1, 1); expect_rep(48'd3, 1); expect_rep(48'd6, 1); expect_rep(48'd10, 1);
    check_log("r1_seq");

    // Two's complement wrap
    do_reset();
    send(48'h7FFF_FFFF_FFFF, 9'd1);
    send(48'd1, 9'd1);
    drain();
    expect_rep(48'h7FFF_FFFF_FFFF, 1);
    expect_rep(48'h8000_0000_0000, 1);
    check_log("wrap");
    send(48'hFFFF_FFFF_FFFF, 9'd1);
    drain();
    expect_rep(48'h7FFF_FFFF_FFFF, 1);
    check_log("wrap_neg");

    // Backpressure: R=3, downstream stalls 5 cycles after the first output
    do_reset();
    send(48'd10, 9'd3);
    m_axis_tready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_hold_data", 64'(m_axis_tdata), 64'd10);
    m_axis_tready = 1'b1;
    drain();
    expect_rep(48'd10, 3);
    check_log("backpressure");

    // rsetting 0 -> 1, 300 -> 256, change mid-burst 4 -> 2
    do_reset();
    send(48'd2, 9'd0);
    drain();
    expect_rep(48'd2, 1);
    check_log("r0");
    send(48'd1, 9'd300);
    drain();
    expect_rep(48'd3, 256);
    check_log("r300");
    send(48'd4, 9'd4);
    send(48'd6, 9'd2);
    drain();
    expect_rep(48'd7, 4);
    expect_rep(48'd13, 2);
    check_log("r_change");

    // Reset mid-burst with two stuffed samples still owed
    do_reset();
    send(48'd9, 9'd4);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_mid_data", 64'(m_axis_tdata), 64'd0);
    chk("rst_mid_ready", 64'(s_axis_tready), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_log.delete();
    send(48'd7, 9'd1);
    drain();
    expect_rep(48'd7, 1);
    check_log("after_rst");

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int k;
      k = int'($urandom_range(0, 99));
      if (k < 2) rsetting = 9'($urandom_range(256, 511));
      else if (k < 5) rsetting = 9'd0;
      else rsetting = 9'($urandom_range(1, 6));
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata = {16'($urandom), 32'($urandom)};
      m_axis_tready = ($urandom_range(0, 3) != 0);
      if (c == 1500) reset_n = 1'b0;
      if (c == 1502) reset_n = 1'b1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
